// File: rtl/chaos_pkg.sv
// Shared constants, channel indices and FSM state type for the chaotic random generator.
package chaos_pkg;

  // Q0.32 "one" (2^32) used to form (1 - x); needs 33 bits.
  localparam logic [32:0] Q032_ONE   = 33'h1_0000_0000;
  // Q2.30 coefficient: product bit 30 is the Q0.32 LSB.
  localparam int unsigned Q230_SHIFT = 30;

  localparam int unsigned NUM_CH   = 5;
  localparam logic [2:0]  CH_X1    = 3'd0;
  localparam logic [2:0]  CH_X2    = 3'd1;
  localparam logic [2:0]  CH_X3    = 3'd2;
  localparam logic [2:0]  CH_Z1    = 3'd3;
  localparam logic [2:0]  CH_Z2    = 3'd4;

  // Issue-to-writeback latency of the step unit and cycles per five-channel set.
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned SET_CYC  = NUM_CH + PIPE_LAT;

  typedef enum logic [1:0] {
    StIdle,
    StWarm,
    StCalc,
    StHold
  } chaos_state_e;

  // A result with no integer-ish magnitude in the top half is treated as collapsed.
  function automatic logic is_stuck(input logic [31:0] y);
    return (y[31:16] == 16'h0000);
  endfunction

endpackage

// File: rtl/logistic_step.sv
// Two-stage pipelined logistic-map step y = R*x*(1-x) in Q0.32 with stuck-state guard.
module logistic_step
  import chaos_pkg::*;
#(
  parameter logic [31:0] R_COEF = 32'hFF5C28F6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] x,
  input  logic [31:0] seed,
  input  logic [2:0]  ch_in,
  output logic        out_vld,
  output logic [31:0] y,
  output logic [2:0]  ch_out
);

  logic [32:0] one_minus_x;
  logic [63:0] p;
  logic [63:0] m;
  logic [31:0] y_raw;
  logic [31:0] y_fix;

  logic        s1_vld;
  logic [31:0] s1_q;
  logic [31:0] s1_seed;
  logic [2:0]  s1_ch;

  logic        unused_bits;

  // Stage 1 arithmetic: x*(1-x); the product never exceeds 2^62.
  assign one_minus_x = Q032_ONE - {1'b0, x};
  assign p           = 64'(x) * 64'(one_minus_x);

  // Stage 2 arithmetic: scale by R; R < 4 keeps m[63:62] at zero.
  assign m     = 64'(s1_q) * 64'(R_COEF);
  assign y_raw = m[Q230_SHIFT +: 32];
  assign y_fix = is_stuck(y_raw) ? s1_seed : y_raw;

  assign unused_bits = ^{p[31:0], m[63:62], m[Q230_SHIFT-1:0]};

  // Pipeline valid bits; reset also flushes in-flight results.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      s1_vld  <= in_vld;
      out_vld <= s1_vld;
    end
  end

  // Pipeline data registers; qualified by the valid bits so no reset needed.
  always_ff @(posedge clk) begin
    s1_q    <= p[63:32];
    s1_seed <= seed;
    s1_ch   <= ch_in;
    y       <= y_fix;
    ch_out  <= s1_ch;
  end

endmodule

// File: rtl/chaos_rand_gen.sv
// Five-channel logistic-map random source sharing one pipelined step unit.
module chaos_rand_gen
  import chaos_pkg::*;
#(
  parameter int unsigned CHAOS_OVLD_W = 32,
  parameter logic [31:0] R_COEF       = 32'hFF5C28F6,
  parameter int unsigned WARMUP_N     = 16,
  parameter logic [31:0] SEED_X1      = 32'h12345678,
  parameter logic [31:0] SEED_X2      = 32'h23456789,
  parameter logic [31:0] SEED_X3      = 32'h3456789A,
  parameter logic [31:0] SEED_Z1      = 32'h456789AB,
  parameter logic [31:0] SEED_Z2      = 32'h56789ABC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reseed,
  output logic [CHAOS_OVLD_W-1:0] rand_x1,
  output logic [CHAOS_OVLD_W-1:0] rand_x2,
  output logic [CHAOS_OVLD_W-1:0] rand_x3,
  output logic [CHAOS_OVLD_W-1:0] rand_z1,
  output logic [CHAOS_OVLD_W-1:0] rand_z2,
  output logic                    rand_vld,
  input  logic                    rand_rdy,
  output logic                    busy
);

  if (CHAOS_OVLD_W != 32) begin : g_bad_width
    $error("chaos_rand_gen supports only CHAOS_OVLD_W == 32");
  end

  localparam logic [31:0] SEEDS [NUM_CH] = '{SEED_X1, SEED_X2, SEED_X3, SEED_Z1, SEED_Z2};
  localparam logic [2:0]  LAST_CYC       = 3'(SET_CYC - 1);
  localparam logic [31:0] LAST_WARM      = 32'(WARMUP_N - 1);

  chaos_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [31:0]  warm_cnt_q, warm_cnt_d;
  logic [31:0]  ch_state_q [NUM_CH];
  logic         load_out;
  logic         vld_d;

  logic         issue_vld;
  logic [31:0]  issue_x;
  logic [31:0]  issue_seed;
  logic         step_flush;
  logic         step_vld;
  logic [31:0]  step_y;
  logic [2:0]   step_ch;

  assign busy       = (state_q == StWarm) || (state_q == StCalc);
  assign step_flush = rst || reseed;

  // Issue one channel per cycle during the first NUM_CH cycles of a set.
  always_comb begin
    issue_vld  = busy && (cnt_q < 3'(NUM_CH));
    issue_x    = ch_state_q[0];
    issue_seed = SEEDS[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (cnt_q == 3'(i)) begin
        issue_x    = ch_state_q[i];
        issue_seed = SEEDS[i];
      end
    end
  end

  logistic_step #(
    .R_COEF (R_COEF)
  ) u_step (
    .clk     (clk),
    .rst     (step_flush),
    .in_vld  (issue_vld),
    .x       (issue_x),
    .seed    (issue_seed),
    .ch_in   (cnt_q),
    .out_vld (step_vld),
    .y       (step_y),
    .ch_out  (step_ch)
  );

  // Next-state logic: a set spans SET_CYC cycles; last cycle carries the final writeback.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    warm_cnt_d = warm_cnt_q;
    load_out   = 1'b0;
    vld_d      = rand_vld;
    unique case (state_q)
      StIdle: begin
        cnt_d      = 3'd0;
        warm_cnt_d = 32'd0;
        state_d    = (WARMUP_N > 0) ? StWarm : StCalc;
      end
      StWarm: begin
        if (cnt_q == LAST_CYC) begin
          cnt_d = 3'd0;
          if (warm_cnt_q == LAST_WARM) begin
            warm_cnt_d = 32'd0;
            state_d    = StCalc;
          end else begin
            warm_cnt_d = warm_cnt_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StCalc: begin
        if (cnt_q == LAST_CYC) begin
          cnt_d    = 3'd0;
          load_out = 1'b1;
          vld_d    = 1'b1;
          state_d  = StHold;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHold: begin
        if (rand_vld && rand_rdy) begin
          vld_d   = 1'b0;
          cnt_d   = 3'd0;
          state_d = StCalc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state; reseed restarts from the seeds but keeps the last delivered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      warm_cnt_q <= 32'd0;
      rand_vld   <= 1'b0;
    end else if (reseed) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      warm_cnt_q <= 32'd0;
      rand_vld   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      warm_cnt_q <= warm_cnt_d;
      rand_vld   <= vld_d;
    end
  end

  // Channel state: seeds on reset/reseed, otherwise step-unit writeback.
  always_ff @(posedge clk) begin
    if (rst || reseed) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state_q[i] <= SEEDS[i];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (step_vld && (step_ch == 3'(i))) begin
          ch_state_q[i] <= step_y;
        end
      end
    end
  end

  // Output words; z2 is taken straight from the step unit as it writes back this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rand_x1 <= '0;
      rand_x2 <= '0;
      rand_x3 <= '0;
      rand_z1 <= '0;
      rand_z2 <= '0;
    end else if (load_out && !reseed) begin
      rand_x1 <= ch_state_q[CH_X1];
      rand_x2 <= ch_state_q[CH_X2];
      rand_x3 <= ch_state_q[CH_X3];
      rand_z1 <= ch_state_q[CH_Z1];
      rand_z2 <= step_y;
    end
  end

endmodule

// File: tb/tb_chaos_rand_gen.sv
// Scoreboard bench for chaos_rand_gen: default-parameter DUT against a reference
// model, plus two R=2.0 instances with hand-derivable sequences.
module tb_chaos_rand_gen;

  typedef logic [4:0][31:0] set_t;

  localparam logic [31:0] R_DEF = 32'hFF5C28F6;
  localparam logic [31:0] R_TWO = 32'h80000000;
  localparam int unsigned WARM_DEF = 16;
  localparam set_t SEEDS_DEF = {32'h56789ABC, 32'h456789AB, 32'h3456789A, 32'h23456789,
                                32'h12345678};
  localparam set_t SEEDS_ALT = {32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000,
                                32'h40000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, reseed, rdy;
  set_t d1_o, d2_o, d3_o;
  logic d1_vld, d2_vld, d3_vld, d1_busy, d2_busy, d3_busy;

  int   checks = 0;
  int   errors = 0;
  int   consumed = 0;
  set_t exp_q[$];

  chaos_rand_gen u_dut1 (
    .clk(clk), .rst(rst), .reseed(reseed),
    .rand_x1(d1_o[0]), .rand_x2(d1_o[1]), .rand_x3(d1_o[2]), .rand_z1(d1_o[3]),
    .rand_z2(d1_o[4]), .rand_vld(d1_vld), .rand_rdy(rdy), .busy(d1_busy)
  );

  chaos_rand_gen #(
    .R_COEF(R_TWO), .WARMUP_N(0),
    .SEED_X1(SEEDS_ALT[0]), .SEED_X2(SEEDS_ALT[1]), .SEED_X3(SEEDS_ALT[2]),
    .SEED_Z1(SEEDS_ALT[3]), .SEED_Z2(SEEDS_ALT[4])
  ) u_dut2 (
    .clk(clk), .rst(rst), .reseed(1'b0),
    .rand_x1(d2_o[0]), .rand_x2(d2_o[1]), .rand_x3(d2_o[2]), .rand_z1(d2_o[3]),
    .rand_z2(d2_o[4]), .rand_vld(d2_vld), .rand_rdy(1'b1), .busy(d2_busy)
  );

  chaos_rand_gen #(
    .R_COEF(R_TWO), .WARMUP_N(2),
    .SEED_X1(SEEDS_ALT[0]), .SEED_X2(SEEDS_ALT[1]), .SEED_X3(SEEDS_ALT[2]),
    .SEED_Z1(SEEDS_ALT[3]), .SEED_Z2(SEEDS_ALT[4])
  ) u_dut3 (
    .clk(clk), .rst(rst), .reseed(1'b0),
    .rand_x1(d3_o[0]), .rand_x2(d3_o[1]), .rand_x3(d3_o[2]), .rand_z1(d3_o[3]),
    .rand_z2(d3_o[4]), .rand_vld(d3_vld), .rand_rdy(1'b1), .busy(d3_busy)
  );

  // Logistic map r*x*(1-x) on integers scaled by 2^32 (x) and 2^30 (r), truncating.
  function automatic logic [31:0] step_ref(input logic [31:0] x, input logic [31:0] r,
                                           input logic [31:0] seed);
    longint unsigned xi, q, y;
    xi = longint'(x);
    q  = (xi * (64'd4294967296 - xi)) / 64'd4294967296;
    y  = ((q * longint'(r)) / 64'd1073741824) % 64'd4294967296;
    if (y < 64'd65536) return seed;
    return 32'(y);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model restart after reset/reseed: warm up from the seeds, then queue n delivered sets.
  task automatic model_restart(input int n);
    set_t st;
    exp_q.delete();
    st = SEEDS_DEF;
    repeat (WARM_DEF) for (int c = 0; c < 5; c++) st[c] = step_ref(st[c], R_DEF, SEEDS_DEF[c]);
    repeat (n) begin
      for (int c = 0; c < 5; c++) st[c] = step_ref(st[c], R_DEF, SEEDS_DEF[c]);
      exp_q.push_back(st);
    end
  endtask

  task automatic wait_vld(input int limit, output int n);
    n = 0;
    while (!d1_vld && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!d1_vld) begin
      errors++;
      $display("FAIL wait_vld timeout after %0d cycles (want vld=1)", n);
    end
  endtask

  task automatic run_sets(input int n);
    int target, cyc;
    target = consumed + n;
    cyc = 0;
    while (consumed < target && cyc < n * 40 + 400) begin
      @(posedge clk); #1;
      rdy = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    checks++;
    if (consumed < target) begin
      errors++;
      $display("FAIL run_sets consumed=%0d want=%0d", consumed, target);
    end
  endtask

  // Monitor: pops expected sets on each handshake and checks HOLD stability.
  initial begin : monitor
    logic hold_chk;
    set_t prev_o, e;
    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check32("hold_vld", {31'd0, d1_vld}, 32'd1);
          for (int c = 0; c < 5; c++) check32("hold_data", d1_o[c], prev_o[c]);
        end
        if (d1_vld && rdy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%h want=none", d1_o);
          end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < 5; c++) check32($sformatf("set%0d_ch%0d", consumed, c),
                                                d1_o[c], e[c]);
          end
          consumed++;
        end
        hold_chk = d1_vld && !rdy && !reseed;
        prev_o   = d1_o;
      end
    end
  end

  // R=2.0, no warm-up: timing plus closed-form first iterates.
  initial begin : chk_dut2
    set_t st;
    int n, last, sets;
    @(negedge rst);
    st = SEEDS_ALT; n = 0; last = 0; sets = 0;
    while (sets < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (d2_vld) begin
        for (int c = 0; c < 5; c++) st[c] = step_ref(st[c], R_TWO, SEEDS_ALT[c]);
        check32("d2_latency", n - last, 8);
        for (int c = 0; c < 5; c++) check32("d2_model", d2_o[c], st[c]);
        if (sets == 0) check32("d2_x1_first", d2_o[0], 32'h60000000);
        if (sets == 1) check32("d2_x1_second", d2_o[0], 32'h78000000);
        check32("d2_x2_fixed", d2_o[1], 32'h80000000);
        check32("d2_z2_guard", d2_o[4], 32'hFFFFFFFF);
        last = n;
        sets++;
      end
    end
    check32("d2_sets_seen", sets, 4);
  end

  // R=2.0, two warm-up sets: first delivery is the third iterate.
  initial begin : chk_dut3
    int n;
    @(negedge rst);
    n = 0;
    while (!d3_vld && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check32("d3_x1_third", d3_o[0], 32'h7F800000);
    check32("d3_z2_guard", d3_o[4], 32'hFFFFFFFF);
  end

  initial begin : stimulus
    int n;
    set_t saved;
    for (int c = 0; c < 5; c++) begin
      assert (SEEDS_DEF[c][31:16] != 16'h0) else $error("default seed %0d collapses", c);
      assert (SEEDS_ALT[c][31:16] != 16'h0) else $error("alt seed %0d collapses", c);
    end
    rst = 1'b1; reseed = 1'b0; rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_vld", {31'd0, d1_vld}, 32'd0);
    check32("rst_busy", {31'd0, d1_busy}, 32'd0);
    check32("rst_x1", d1_o[0], 32'd0);
    check32("rst_z2", d1_o[4], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_restart(150);

    run_sets(60);

    // Long stall, then a one-cycle ready pulse.
    rdy = 1'b0;
    wait_vld(400, n);
    repeat (20) @(posedge clk);
    #1 rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    check32("pulse_vld_low", {31'd0, d1_vld}, 32'd0);
    n = 0;
    while (!d1_vld && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check32("pulse_next_set_gap", n, 7);
    rdy = 1'b1;

    // Reseed while calculating: vld low next cycle, words held.
    wait_vld(400, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    saved = d1_o;
    reseed = 1'b1;
    @(posedge clk); #1;
    reseed = 1'b0;
    model_restart(150);
    check32("reseed_vld", {31'd0, d1_vld}, 32'd0);
    check32("reseed_busy", {31'd0, d1_busy}, 32'd0);
    for (int c = 0; c < 5; c++) check32("reseed_hold", d1_o[c], saved[c]);

    run_sets(30);

    // Reseed coinciding with a handshake: the set is consumed, none duplicated.
    rdy = 1'b0;
    wait_vld(400, n);
    rdy = 1'b1;
    reseed = 1'b1;
    @(posedge clk); #1;
    reseed = 1'b0;
    model_restart(150);
    check32("reseed_hs_vld", {31'd0, d1_vld}, 32'd0);

    run_sets(20);

    // Reset while holding.
    rdy = 1'b0;
    wait_vld(400, n);
    rst = 1'b1;
    @(posedge clk); #1;
    check32("midrst_vld", {31'd0, d1_vld}, 32'd0);
    check32("midrst_busy", {31'd0, d1_busy}, 32'd0);
    check32("midrst_x3", d1_o[2], 32'd0);
    rst = 1'b0;
    model_restart(150);

    run_sets(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
